// File: rtl/prm_chk_pkg.sv
// rtl/prm_chk_pkg.sv - shared sizes, edge code type and scheduler states for the PRM checker scheduler
package prm_chk_pkg;
    localparam int N_CHK  = 256;
    localparam int GRP    = 16;
    localparam int NG     = N_CHK / GRP;
    localparam int CODE_W = 15;
    localparam int ID_W   = 8;
    localparam int IDX_W  = $clog2(N_CHK);
    localparam int GRP_W  = $clog2(GRP);
    localparam int NG_W   = $clog2(NG);

    typedef logic [CODE_W-1:0] edge_code_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } sched_state_t;
endpackage

// File: rtl/prm_edge_chk_sched_if.sv
// rtl/prm_edge_chk_sched_if.sv - query in / result out handshake bundle of the checker scheduler
interface prm_edge_chk_sched_if;
    import prm_chk_pkg::*;

    logic             in_valid;
    logic             in_ready;
    edge_code_t       in_code;
    logic [ID_W-1:0]  in_id;
    logic             out_valid;
    logic             out_ready;
    logic [ID_W-1:0]  out_id;
    logic             out_blocked;
    logic [IDX_W-1:0] out_hit_idx;

    modport master (
        output in_valid, in_code, in_id, out_ready,
        input  in_ready, out_valid, out_id, out_blocked, out_hit_idx
    );

    modport slave (
        input  in_valid, in_code, in_id, out_ready,
        output in_ready, out_valid, out_id, out_blocked, out_hit_idx
    );
endinterface

// File: rtl/prm_grp_prio_enc.sv
// rtl/prm_grp_prio_enc.sv - lowest-set-bit priority encoder over one checker group
module prm_grp_prio_enc #(
    parameter int W  = 16,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic          any,
    output logic [IW-1:0] idx
);
    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/prm_edge_chk_sched.sv
// rtl/prm_edge_chk_sched.sv - broadcasts one edge code to the checker bank and scans its masks group by group
module prm_edge_chk_sched
    import prm_chk_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    prm_edge_chk_sched_if.slave  bus,
    output edge_code_t           chk_code,
    input  logic [N_CHK-1:0]     chk_mask,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic                 cfg_en,
    output logic                 cfg_ack,
    output logic [15:0]          stat_queries,
    output logic [15:0]          stat_blocked
);
    sched_state_t     state_q, state_d;
    logic [NG_W-1:0]  grp_q, grp_d;
    edge_code_t       chk_code_q, chk_code_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [N_CHK-1:0] en_mask_q, en_mask_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic [15:0]      stat_queries_q, stat_queries_d;
    logic [15:0]      stat_blocked_q, stat_blocked_d;

    logic [IDX_W-1:0] base;
    logic [GRP-1:0]   slice;
    logic             enc_any;
    logic [GRP_W-1:0] enc_idx;

    assign base  = {grp_q, {GRP_W{1'b0}}};
    assign slice = chk_mask[base +: GRP] & en_mask_q[base +: GRP];

    prm_grp_prio_enc #(.W(GRP)) u_enc (
        .vec (slice),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_comb begin
        state_d        = state_q;
        grp_d          = grp_q;
        chk_code_d     = chk_code_q;
        id_d           = id_q;
        hit_d          = hit_q;
        idx_d          = idx_q;
        in_ready_d     = in_ready_q;
        out_valid_d    = out_valid_q;
        en_mask_d      = en_mask_q;
        cfg_ack_d      = 1'b0;
        stat_queries_d = stat_queries_q;
        stat_blocked_d = stat_blocked_q;
        case (state_q)
            IDLE: begin
                // The enable write lands on the same edge as an accept, so that query sees it.
                if (cfg_we) begin
                    en_mask_d[cfg_idx] = cfg_en;
                    cfg_ack_d          = 1'b1;
                end
                if (bus.in_valid && in_ready_q) begin
                    state_d    = EVAL;
                    chk_code_d = bus.in_code;
                    id_d       = bus.in_id;
                    hit_d      = 1'b0;
                    idx_d      = '0;
                    grp_d      = '0;
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            EVAL: begin
                if (enc_any && !hit_q) begin
                    hit_d = 1'b1;
                    idx_d = base | IDX_W'(enc_idx);
                end
                if (grp_q == NG_W'(NG - 1) || (EARLY_EXIT && enc_any)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    if (stat_queries_q != 16'hFFFF) stat_queries_d = stat_queries_q + 16'd1;
                    if (hit_q && stat_blocked_q != 16'hFFFF) stat_blocked_d = stat_blocked_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q        <= IDLE;
            grp_q          <= '0;
            chk_code_q     <= '0;
            id_q           <= '0;
            hit_q          <= 1'b0;
            idx_q          <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            en_mask_q      <= '1;
            cfg_ack_q      <= 1'b0;
            stat_queries_q <= '0;
            stat_blocked_q <= '0;
        end else begin
            state_q        <= state_d;
            grp_q          <= grp_d;
            chk_code_q     <= chk_code_d;
            id_q           <= id_d;
            hit_q          <= hit_d;
            idx_q          <= idx_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            en_mask_q      <= en_mask_d;
            cfg_ack_q      <= cfg_ack_d;
            stat_queries_q <= stat_queries_d;
            stat_blocked_q <= stat_blocked_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_id      = id_q;
    assign bus.out_blocked = hit_q;
    assign bus.out_hit_idx = idx_q;
    assign chk_code        = chk_code_q;
    assign cfg_ack         = cfg_ack_q;
    assign stat_queries    = stat_queries_q;
    assign stat_blocked    = stat_blocked_q;
endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// tb/tb_prm_edge_chk_sched.sv - bench driving an early-exit and a full-scan scheduler with shared stimulus
module tb_prm_edge_chk_sched;
    import prm_chk_pkg::*;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic             blk;
        logic [IDX_W-1:0] idx;
        int               lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic             in_valid = 1'b1;
    logic             out_ready = 1'b1;
    edge_code_t       in_code = '0;
    logic [ID_W-1:0]  in_id = '0;
    logic [N_CHK-1:0] mask = '0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic             cfg_en = 1'b0;
    edge_code_t       cc1, cc0;
    logic             ack1, ack0;
    logic [15:0]      sq1, sb1, sq0, sb0;

    int   total = 0;
    int   bad = 0;
    int   t_acc = 0;
    int   exp_q = 0;
    int   exp_b = 0;
    exp_t q1[$];
    exp_t q0[$];

    prm_edge_chk_sched_if bus1();
    prm_edge_chk_sched_if bus0();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_code   = in_code;
    assign bus1.in_id     = in_id;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_code   = in_code;
    assign bus0.in_id     = in_id;
    assign bus0.out_ready = out_ready;

    prm_edge_chk_sched #(.EARLY_EXIT(1'b1)) dut (
        .CLK (CLK), .RST_N (RST_N), .bus (bus1.slave), .chk_code (cc1), .chk_mask (mask),
        .cfg_we (cfg_we), .cfg_idx (cfg_idx), .cfg_en (cfg_en), .cfg_ack (ack1),
        .stat_queries (sq1), .stat_blocked (sb1)
    );

    prm_edge_chk_sched #(.EARLY_EXIT(1'b0)) dut_full (
        .CLK (CLK), .RST_N (RST_N), .bus (bus0.slave), .chk_code (cc0), .chk_mask (mask),
        .cfg_we (cfg_we), .cfg_idx (cfg_idx), .cfg_en (cfg_en), .cfg_ack (ack0),
        .stat_queries (sq0), .stat_blocked (sb0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
        chk("stat_queries", {sq1, sq0}, {exp_q[15:0], exp_q[15:0]});
        chk("stat_blocked", {sb1, sb0}, {exp_b[15:0], exp_b[15:0]});
    endtask

    task automatic send(input edge_code_t code, input logic [ID_W-1:0] id, input logic blk,
                        input logic [IDX_W-1:0] idx, input int lat1, input int lat0,
                        input logic with_cfg, input logic [IDX_W-1:0] cidx, input logic cen);
        int n = 0;
        q1.push_back('{id, blk, idx, lat1});
        q0.push_back('{id, blk, idx, lat0});
        @(negedge CLK);
        while (!(bus1.in_ready && bus0.in_ready) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("in_ready_before_send", {bus1.in_ready, bus0.in_ready}, 2'b11);
        in_valid = 1'b1;
        in_code  = code;
        in_id    = id;
        cfg_we   = with_cfg;
        cfg_idx  = cidx;
        cfg_en   = cen;
        t_acc    = cyc;
        @(negedge CLK);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("chk_code", {cc1, cc0}, {code, code});
        if (with_cfg) chk("cfg_ack_with_accept", {ack1, ack0}, 2'b11);
    endtask

    task automatic collect();
        bit   s1 = 1'b0;
        bit   s0 = 1'b0;
        int   n = 0;
        exp_t e;
        while (!(s1 && s0) && n < 60) begin
            if (bus1.out_valid && !s1) begin
                s1 = 1'b1;
                e  = q1.pop_front();
                chk("ee_id", bus1.out_id, e.id);
                chk("ee_blocked", bus1.out_blocked, e.blk);
                chk("ee_hit_idx", bus1.out_hit_idx, e.idx);
                chk("ee_latency", cyc - t_acc, e.lat);
            end
            if (bus0.out_valid && !s0) begin
                s0 = 1'b1;
                e  = q0.pop_front();
                chk("full_id", bus0.out_id, e.id);
                chk("full_blocked", bus0.out_blocked, e.blk);
                chk("full_hit_idx", bus0.out_hit_idx, e.idx);
                chk("full_latency", cyc - t_acc, e.lat);
            end
            if (!(s1 && s0)) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("result_seen", {s1, s0}, 2'b11);
    endtask

    initial begin
        int nv;
        // Reset held with a query pending: nothing may be accepted.
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", {bus1.in_ready, bus0.in_ready}, 2'b00);
        chk("rst_out_valid", {bus1.out_valid, bus0.out_valid}, 2'b00);
        chk("rst_chk_code", {cc1, cc0}, '0);
        chk("rst_cfg_ack", {ack1, ack0}, 2'b00);
        chk_stats();
        in_valid = 1'b0;
        RST_N    = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", {bus1.in_ready, bus0.in_ready}, 2'b11);

        mask = '0;
        send(15'h1234, 8'd1, 1'b0, 8'd0, 17, 17, 1'b0, 8'd0, 1'b0);
        collect();
        @(negedge CLK);
        exp_q = 1;
        chk_stats();

        mask = '0; mask[37] = 1'b1; mask[200] = 1'b1;
        send(15'h0a5a, 8'd2, 1'b1, 8'd37, 4, 17, 1'b0, 8'd0, 1'b0);
        collect();
        mask = '0; mask[3] = 1'b1; mask[5] = 1'b1;
        send(15'h7fff, 8'd3, 1'b1, 8'd3, 2, 17, 1'b0, 8'd0, 1'b0);
        collect();
        mask = '0; mask[255] = 1'b1;
        send(15'h0001, 8'd4, 1'b1, 8'd255, 17, 17, 1'b0, 8'd0, 1'b0);
        collect();
        @(negedge CLK);
        exp_q = 4; exp_b = 3;
        chk_stats();

        cfg_we = 1'b1; cfg_idx = 8'd37; cfg_en = 1'b0;
        @(negedge CLK);
        cfg_we = 1'b0;
        chk("cfg_ack_pulse", {ack1, ack0}, 2'b11);
        @(negedge CLK);
        chk("cfg_ack_clear", {ack1, ack0}, 2'b00);
        mask = '0; mask[37] = 1'b1; mask[200] = 1'b1;
        send(15'h2222, 8'd5, 1'b1, 8'd200, 14, 17, 1'b0, 8'd0, 1'b0);
        collect();
        @(negedge CLK);
        exp_q = 5; exp_b = 4;

        out_ready = 1'b0;
        send(15'h3333, 8'd6, 1'b1, 8'd200, 14, 17, 1'b0, 8'd0, 1'b0);
        collect();
        for (int i = 0; i < 10; i++) begin
            cfg_we = 1'b1; cfg_idx = 8'd200; cfg_en = 1'b0;
            @(negedge CLK);
            chk("bp_hold_flags", {bus1.out_valid, bus0.out_valid, bus1.in_ready, bus0.in_ready, ack1, ack0}, 6'b110000);
            chk("bp_hold_result", {bus1.out_id, bus1.out_hit_idx, bus0.out_id, bus0.out_hit_idx}, {8'd6, 8'd200, 8'd6, 8'd200});
            chk_stats();
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_release", {bus1.out_valid, bus0.out_valid}, 2'b00);
        exp_q = 6; exp_b = 5;
        chk_stats();

        send(15'h4444, 8'd7, 1'b1, 8'd37, 4, 17, 1'b1, 8'd37, 1'b1);
        collect();
        mask = '0; mask[200] = 1'b1;
        send(15'h5555, 8'd8, 1'b1, 8'd200, 14, 17, 1'b0, 8'd0, 1'b0);
        collect();
        @(negedge CLK);
        exp_q = 8; exp_b = 7;
        chk_stats();

        // Reset in the middle of a scan drops the query and restores all enables.
        cfg_we = 1'b1; cfg_idx = 8'd37; cfg_en = 1'b0;
        @(negedge CLK);
        cfg_we = 1'b0;
        mask = '0;
        send(15'h6666, 8'd9, 1'b0, 8'd0, 17, 17, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 20 && cyc < t_acc + 5; i++) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        q1.delete();
        q0.delete();
        exp_q = 0; exp_b = 0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus1.out_valid || bus0.out_valid) nv++;
        end
        chk("midscan_rst_no_output", nv, 0);
        chk_stats();
        mask = '0; mask[37] = 1'b1; mask[200] = 1'b1;
        send(15'h0abc, 8'd10, 1'b1, 8'd37, 4, 17, 1'b0, 8'd0, 1'b0);
        collect();
        @(negedge CLK);
        exp_q = 1; exp_b = 1;
        chk_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
